// File: rtl/fsm_initiator.sv
// Initiator side of the start/done job handshake: issues one start pulse per job of a batch,
// waits for done with a per-job watchdog, and inserts a fixed idle gap between jobs.
module fsm_initiator #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             go,
    input  logic [CNT_W-1:0] num_jobs,
    input  logic             abort,
    input  logic             done,
    output logic             start,
    output logic             busy,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] jobs_done,
    output logic             batch_done,
    output logic             timeout_err
);

    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StWait  = 2'b10,
        StGap   = 2'b11
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] jobs_done_q;
    logic [TmrW-1:0]  timer_q;
    logic [GapW-1:0]  gap_q;
    logic             batch_done_q;
    logic             timeout_err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            jobs_done_q   <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
            batch_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            batch_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (go) begin
                        jobs_done_q   <= '0;
                        timeout_err_q <= 1'b0;
                        if (num_jobs != '0) begin
                            remaining_q <= num_jobs;
                            state_q     <= StStart;
                        end else begin
                            batch_done_q <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        timer_q <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // abort beats done, done beats the watchdog in its final cycle
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (done) begin
                        jobs_done_q <= jobs_done_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            batch_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            gap_q   <= '0;
                            state_q <= StGap;
                        end
                    end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                        timer_q       <= TmrW'(TIMEOUT);
                        timeout_err_q <= 1'b1;
                        state_q       <= StIdle;
                    end else begin
                        timer_q <= timer_q + TmrW'(1);
                    end
                end
                StGap: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                        state_q <= StStart;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start       = (state_q == StStart);
    assign busy        = (state_q != StIdle);
    assign state_out   = state_q;
    assign jobs_done   = jobs_done_q;
    assign batch_done  = batch_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fsm_initiator.sv
// Bench for fsm_initiator: each batch is planned as a per-cycle timeline of expected outputs
// derived from job delays, abort point and spurious inputs, then replayed against the DUT.
module tb_fsm_initiator;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;
    localparam int TL      = 256;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             go = 1'b0;
    logic [CNT_W-1:0] num_jobs = '0;
    logic             abort = 1'b0;
    logic             done = 1'b0;
    logic             start;
    logic             busy;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] jobs_done;
    logic             batch_done;
    logic             timeout_err;

    fsm_initiator #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .go          (go),
        .num_jobs    (num_jobs),
        .abort       (abort),
        .done        (done),
        .start       (start),
        .busy        (busy),
        .state_out   (state_out),
        .jobs_done   (jobs_done),
        .batch_done  (batch_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected timeline (index = cycle offset from the cycle go is driven) and stimulus
    logic [1:0]       e_st  [TL];
    logic [CNT_W-1:0] e_jd  [TL];
    logic             e_bd  [TL];
    logic             e_to  [TL];
    logic             d_go  [TL];
    logic [CNT_W-1:0] d_num [TL];
    logic             d_done[TL];
    logic             d_abt [TL];
    int               n_cyc;
    int               dly[8];
    int               last_jd = 0;
    logic             last_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_from(input int c, input logic [1:0] st, input int jd, input logic to);
        for (int i = c; i < TL; i++) begin
            e_st[i] = st;
            e_jd[i] = CNT_W'(jd);
            e_to[i] = to;
        end
    endtask

    // Plan a batch of n jobs; dly[j] is the WAIT cycle (1..TIMEOUT) carrying done, 0 = never.
    task automatic plan(input int n, input int abort_at, input logic spur);
        int cs, wend, jd;
        for (int i = 0; i < TL; i++) begin
            e_st[i] = 2'b00; e_jd[i] = CNT_W'(last_jd); e_to[i] = last_to; e_bd[i] = 1'b0;
            d_go[i] = 1'b0; d_num[i] = '0; d_done[i] = 1'b0; d_abt[i] = 1'b0;
        end
        d_go[0]  = 1'b1;
        d_num[0] = CNT_W'(n);
        if (n == 0) begin
            set_from(1, 2'b00, 0, 1'b0);
            e_bd[1] = 1'b1;
            n_cyc = 3;
            d_done[n_cyc-1] = spur;
            return;
        end
        cs = 1;
        jd = 0;
        for (int j = 0; j < n; j++) begin
            set_from(cs, 2'b01, jd, 1'b0);
            if (spur) begin
                d_done[cs] = 1'b1; d_go[cs] = 1'b1; d_num[cs] = 8'd7;
            end
            wend = (dly[j] == 0) ? cs + TIMEOUT : cs + dly[j];
            if (abort_at != cs) set_from(cs + 1, 2'b10, jd, 1'b0);
            if (abort_at >= cs && abort_at <= wend) begin
                d_abt[abort_at] = 1'b1;
                if (dly[j] != 0 && abort_at == wend) d_done[abort_at] = 1'b1;
                set_from(abort_at + 1, 2'b00, jd, 1'b0);
                n_cyc = abort_at + 3;
                d_done[n_cyc-1] = spur;
                return;
            end
            if (dly[j] == 0) begin
                set_from(wend + 1, 2'b00, jd, 1'b1);
                n_cyc = wend + 3;
                d_done[n_cyc-1] = spur;
                return;
            end
            d_done[wend] = 1'b1;
            jd++;
            if (j == n - 1) begin
                set_from(wend + 1, 2'b00, jd, 1'b0);
                e_bd[wend+1] = 1'b1;
                n_cyc = wend + 3;
                d_done[n_cyc-1] = spur;
                return;
            end
            set_from(wend + 1, 2'b11, jd, 1'b0);
            for (int g = wend + 1; g <= wend + GAP; g++) d_done[g] = spur;
            if (abort_at > wend && abort_at <= wend + GAP) begin
                d_abt[abort_at] = 1'b1;
                set_from(abort_at + 1, 2'b00, jd, 1'b0);
                n_cyc = abort_at + 3;
                d_done[n_cyc-1] = spur;
                return;
            end
            cs = wend + GAP + 1;
        end
    endtask

    task automatic play(input string name);
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            chk({name, ".state"},  32'(state_out),   32'(e_st[c]));
            chk({name, ".start"},  32'(start),       32'(e_st[c] == 2'b01));
            chk({name, ".busy"},   32'(busy),        32'(e_st[c] != 2'b00));
            chk({name, ".jobs"},   32'(jobs_done),   32'(e_jd[c]));
            chk({name, ".bdone"},  32'(batch_done),  32'(e_bd[c]));
            chk({name, ".timeout"},32'(timeout_err), 32'(e_to[c]));
            go = d_go[c]; num_jobs = d_num[c]; done = d_done[c]; abort = d_abt[c];
        end
        last_jd = int'(e_jd[n_cyc-1]);
        last_to = e_to[n_cyc-1];
    endtask

    task automatic check_zero(input string name);
        chk({name, ".state"},  32'(state_out),   32'd0);
        chk({name, ".start"},  32'(start),       32'd0);
        chk({name, ".busy"},   32'(busy),        32'd0);
        chk({name, ".jobs"},   32'(jobs_done),   32'd0);
        chk({name, ".bdone"},  32'(batch_done),  32'd0);
        chk({name, ".timeout"},32'(timeout_err), 32'd0);
    endtask

    task automatic set_dly(input int v);
        for (int i = 0; i < 8; i++) dly[i] = v;
    endtask

    initial begin
        #11 n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_zero("reset");
        end

        set_dly(2);
        plan(3, -1, 1'b0);
        play("normal");

        set_dly(0);
        plan(2, -1, 1'b0);
        play("watchdog");
        set_dly(1);
        plan(1, -1, 1'b0);
        play("recover");

        set_dly(TIMEOUT);
        plan(2, -1, 1'b0);
        play("last_wait");
        plan(0, -1, 1'b0);
        play("zero_jobs");

        set_dly(2);
        plan(4, 4, 1'b0);
        play("abort_gap");
        set_dly(3);
        plan(2, 4, 1'b0);
        play("abort_done");
        set_dly(2);
        plan(3, 1, 1'b0);
        play("abort_start");

        set_dly(2);
        plan(3, -1, 1'b1);
        play("ignored");

        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                dly[i] = (r == 0) ? 0 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 6));
            end
            plan(int'($urandom_range(0, 5)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : -1,
                 1'($urandom_range(0, 1)));
            play("random");
        end

        // Reset mid-WAIT of the second job, with jobs_done already 1
        dly[0] = 1; dly[1] = 5; dly[2] = 5;
        plan(3, -1, 1'b0);
        n_cyc = 8;
        play("pre_reset");
        n_rst = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        done = 1'b0; go = 1'b0; abort = 1'b0;
        n_rst = 1'b1;
        last_jd = 0;
        last_to = 1'b0;
        set_dly(1);
        plan(1, -1, 1'b0);
        play("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
